sd_dat_reader: RTL and testbench

Multi-block, multi-lane SD DAT-line receiver for the SD host. It runs alongside the command controller, which issues CMD17/CMD18/CMD12 and drives `sdclk`. This block samples DAT on `sdclk` rising edges and deserialises 1-bit or 4-bit block data into a byte stream. Each block's per-lane CRC16 is checked, and per-block and per-transfer status is reported. It adds to the single-block, 1-bit, unchecked sector read the following: lane-width generalisation, multi-block transfers, CRC checking and abort.

---
 rtl/sd_dat_reader.sv | 223 ++++++++++++++++++++++
 tb/tb_sd_dat_reader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_dat_reader.sv
// SD DAT-line block receiver: 1- or 4-lane deserialiser with per-lane CRC16 check,
// multi-block sequencing, start-bit timeout and abort.
module sd_dat_reader #(
  parameter int unsigned LANES         = 1,
  parameter int unsigned BLOCK_BYTES   = 512,
  parameter int unsigned TIMEOUT_EDGES = 1000000,
  parameter int unsigned AW            = $clog2(BLOCK_BYTES)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             sdclk,
  input  logic [LANES-1:0] sddat,
  input  logic             start,
  input  logic [15:0]      nblocks,
  input  logic             abort,
  output logic             busy,
  output logic             blk_done,
  output logic             blk_crc_ok,
  output logic             done,
  output logic             err_crc,
  output logic             err_timeout,
  output logic             outen,
  output logic [AW-1:0]    outaddr,
  output logic [15:0]      outblk,
  output logic [7:0]       outbyte
);

  localparam int unsigned CW         = 32;
  localparam int unsigned EPB        = 8 / LANES;
  localparam int unsigned DATA_EDGES = BLOCK_BYTES * EPB;

  typedef enum logic [2:0] {S_IDLE, S_WAIT_START, S_DATA, S_CRC, S_STOP} state_e;

  state_e                 state_q, state_d;
  logic                   sdclk_l_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [15:0]            nblk_q, nblk_d;
  logic [7:0]             sr_q, sr_d;
  logic [LANES-1:0][15:0] crc_calc_q, crc_calc_d;
  logic [LANES-1:0][15:0] crc_rx_q, crc_rx_d;
  logic                   busy_q, busy_d, blk_done_q, blk_done_d, blk_crc_ok_q, blk_crc_ok_d;
  logic                   done_q, done_d, err_crc_q, err_crc_d, err_timeout_q, err_timeout_d;
  logic                   outen_q, outen_d;
  logic [AW-1:0]          outaddr_q, outaddr_d;
  logic [15:0]            outblk_q, outblk_d;
  logic [7:0]             outbyte_q, outbyte_d;
  logic                   edge_c, blk_ok_c;

  // CRC16-CCITT (0x1021) single-bit step
  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  assign edge_c   = sdclk & ~sdclk_l_q;
  assign blk_ok_c = (crc_rx_q == crc_calc_q) && (&sddat);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      sdclk_l_q     <= 1'b0;
      cnt_q         <= '0;
      nblk_q        <= 16'd1;
      sr_q          <= '0;
      crc_calc_q    <= '0;
      crc_rx_q      <= '0;
      busy_q        <= 1'b0;
      blk_done_q    <= 1'b0;
      blk_crc_ok_q  <= 1'b0;
      done_q        <= 1'b0;
      err_crc_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      outen_q       <= 1'b0;
      outaddr_q     <= '0;
      outblk_q      <= '0;
      outbyte_q     <= '0;
    end else begin
      state_q       <= state_d;
      sdclk_l_q     <= sdclk;
      cnt_q         <= cnt_d;
      nblk_q        <= nblk_d;
      sr_q          <= sr_d;
      crc_calc_q    <= crc_calc_d;
      crc_rx_q      <= crc_rx_d;
      busy_q        <= busy_d;
      blk_done_q    <= blk_done_d;
      blk_crc_ok_q  <= blk_crc_ok_d;
      done_q        <= done_d;
      err_crc_q     <= err_crc_d;
      err_timeout_q <= err_timeout_d;
      outen_q       <= outen_d;
      outaddr_q     <= outaddr_d;
      outblk_q      <= outblk_d;
      outbyte_q     <= outbyte_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    nblk_d        = nblk_q;
    sr_d          = sr_q;
    crc_calc_d    = crc_calc_q;
    crc_rx_d      = crc_rx_q;
    blk_done_d    = 1'b0;
    blk_crc_ok_d  = blk_crc_ok_q;
    done_d        = 1'b0;
    err_crc_d     = err_crc_q;
    err_timeout_d = err_timeout_q;
    outen_d       = 1'b0;
    outaddr_d     = '0;
    outblk_d      = outblk_q;
    outbyte_d     = outbyte_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          nblk_d        = (nblocks == 16'd0) ? 16'd1 : nblocks;
          outblk_d      = '0;
          cnt_d         = '0;
          err_crc_d     = 1'b0;
          err_timeout_d = 1'b0;
          state_d       = S_WAIT_START;
        end
      end
      S_WAIT_START: begin
        if (edge_c) begin
          if (sddat == '0) begin
            cnt_d      = '0;
            crc_calc_d = '0;
            crc_rx_d   = '0;
            state_d    = S_DATA;
          end else begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_d > CW'(TIMEOUT_EDGES)) begin
              err_timeout_d = 1'b1;
              done_d        = 1'b1;
              state_d       = S_IDLE;
            end
          end
        end
      end
      S_DATA: begin
        if (edge_c) begin
          sr_d = {sr_q[7-LANES:0], sddat};
          for (int unsigned l = 0; l < LANES; l++) begin
            crc_calc_d[l] = crc16_step(crc_calc_q[l], sddat[l]);
          end
          // last edge of a byte: publish it on the following cycle
          if ((cnt_q % CW'(EPB)) == CW'(EPB - 1)) begin
            outen_d   = 1'b1;
            outaddr_d = AW'(cnt_q / CW'(EPB));
            outbyte_d = sr_d;
          end
          if (cnt_q == CW'(DATA_EDGES - 1)) begin
            cnt_d   = '0;
            state_d = S_CRC;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_CRC: begin
        if (edge_c) begin
          for (int unsigned l = 0; l < LANES; l++) begin
            crc_rx_d[l] = {crc_rx_q[l][14:0], sddat[l]};
          end
          if (cnt_q == CW'(15)) begin
            cnt_d   = '0;
            state_d = S_STOP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_STOP: begin
        if (edge_c) begin
          blk_done_d   = 1'b1;
          blk_crc_ok_d = blk_ok_c;
          if (!blk_ok_c) err_crc_d = 1'b1;
          if (16'(outblk_q + 16'd1) == nblk_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            outblk_d = 16'(outblk_q + 16'd1);
            cnt_d    = '0;
            state_d  = S_WAIT_START;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // abort overrides whatever the active state decided this cycle
    if (abort && (state_q != S_IDLE)) begin
      state_d       = S_IDLE;
      outen_d       = 1'b0;
      outaddr_d     = '0;
      outbyte_d     = outbyte_q;
      blk_done_d    = 1'b0;
      blk_crc_ok_d  = blk_crc_ok_q;
      done_d        = 1'b0;
      outblk_d      = outblk_q;
      err_crc_d     = err_crc_q;
      err_timeout_d = err_timeout_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  assign busy        = busy_q;
  assign blk_done    = blk_done_q;
  assign blk_crc_ok  = blk_crc_ok_q;
  assign done        = done_q;
  assign err_crc     = err_crc_q;
  assign err_timeout = err_timeout_q;
  assign outen       = outen_q;
  assign outaddr     = outaddr_q;
  assign outblk      = outblk_q;
  assign outbyte     = outbyte_q;

endmodule

// File: tb/tb_sd_dat_reader.sv
// Directed bench for sd_dat_reader: a 1-lane and a 4-lane instance share clk/sdclk/rstn.
module tb_sd_dat_reader;

  logic        clk = 1'b0;
  logic        rstn, sdclk;
  logic        dat_a;
  logic [3:0]  dat_b;
  logic        start_a, start_b, abort_a, abort_b;
  logic [15:0] nblk_a, nblk_b;

  logic        busy_a, blk_done_a, blk_crc_ok_a, done_a, err_crc_a, err_timeout_a, outen_a;
  logic [8:0]  outaddr_a;
  logic [15:0] outblk_a;
  logic [7:0]  outbyte_a;
  logic        busy_b, blk_done_b, blk_crc_ok_b, done_b, err_crc_b, err_timeout_b, outen_b;
  logic [8:0]  outaddr_b;
  logic [15:0] outblk_b;
  logic [7:0]  outbyte_b;

  int n_chk = 0, n_fail = 0;
  int oe_a = 0, bd_a = 0, dn_a = 0, dnbd_a = 0, idx_a = 0;
  int oe_b = 0, bd_b = 0, dn_b = 0, idx_b = 0;
  logic       ok_a_last = 1'b0;
  logic [7:0] okh_b = '0;
  int b_oe, b_bd, b_dn;

  always #5 clk = ~clk;

  sd_dat_reader #(.LANES(1), .BLOCK_BYTES(512), .TIMEOUT_EDGES(100)) u_a (
    .clk(clk), .rstn(rstn), .sdclk(sdclk), .sddat(dat_a), .start(start_a),
    .nblocks(nblk_a), .abort(abort_a), .busy(busy_a), .blk_done(blk_done_a),
    .blk_crc_ok(blk_crc_ok_a), .done(done_a), .err_crc(err_crc_a),
    .err_timeout(err_timeout_a), .outen(outen_a), .outaddr(outaddr_a),
    .outblk(outblk_a), .outbyte(outbyte_a));

  sd_dat_reader #(.LANES(4), .BLOCK_BYTES(512), .TIMEOUT_EDGES(100)) u_b (
    .clk(clk), .rstn(rstn), .sdclk(sdclk), .sddat(dat_b), .start(start_b),
    .nblocks(nblk_b), .abort(abort_b), .busy(busy_b), .blk_done(blk_done_b),
    .blk_crc_ok(blk_crc_ok_b), .done(done_b), .err_crc(err_crc_b),
    .err_timeout(err_timeout_b), .outen(outen_b), .outaddr(outaddr_b),
    .outblk(outblk_b), .outbyte(outbyte_b));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  // byte stream and block-status monitor, sampled on the falling edge
  initial forever begin
    @(negedge clk);
    if (!rstn) begin
      idx_a = 0;
      idx_b = 0;
    end else begin
      if (start_a) idx_a = 0;
      if (start_b) idx_b = 0;
      if (outen_a) begin
        check("a_byte", 64'({outblk_a, 7'd0, outaddr_a, outbyte_a}),
              64'({16'(idx_a / 512), 7'd0, 9'(idx_a % 512), 8'hFF}));
        idx_a++;
        oe_a++;
      end
      if (outen_b) begin
        check("b_byte", 64'({outblk_b, 7'd0, outaddr_b, outbyte_b}),
              64'({16'(idx_b / 512), 7'd0, 9'(idx_b % 512), 8'(idx_b % 512)}));
        idx_b++;
        oe_b++;
      end
      if (blk_done_a) begin bd_a++; ok_a_last = blk_crc_ok_a; end
      if (done_a) dn_a++;
      if (done_a && blk_done_a) dnbd_a++;
      if (blk_done_b) begin bd_b++; okh_b = {okh_b[6:0], blk_crc_ok_b}; end
      if (done_b) dn_b++;
    end
  end

  // one sdclk period (two clk cycles) carrying value v on DAT
  task automatic sd_bit(input logic [3:0] v);
    dat_a = v[0];
    dat_b = v;
    sdclk = 1'b0;
    @(posedge clk); #1;
    sdclk = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit lane4, input logic [15:0] n);
    if (lane4) begin nblk_b = n; start_b = 1'b1; end
    else begin nblk_a = n; start_a = 1'b1; end
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // 512 bytes of 0xFF on DAT0; CRC16 of that stream is 0x7FA1
  task automatic send_block_a();
    logic [15:0] c;
    c = 16'h7FA1;
    sd_bit(4'hF); sd_bit(4'hF); sd_bit(4'h0);
    for (int i = 0; i < 4096; i++) sd_bit(4'hF);
    for (int k = 15; k >= 0; k--) sd_bit({3'b111, c[k]});
    sd_bit(4'hF);
  endtask

  // 512 bytes, byte i = i[7:0], high nibble first; optional flip of DAT2 CRC MSB
  task automatic send_block_b(input bit flip);
    logic [3:0][15:0] c;
    logic [7:0]       by;
    logic [3:0]       v;
    c = '0;
    for (int i = 0; i < 512; i++) begin
      by = 8'(i);
      for (int l = 0; l < 4; l++) c[l] = crc_step(c[l], by[4+l]);
      for (int l = 0; l < 4; l++) c[l] = crc_step(c[l], by[l]);
    end
    sd_bit(4'hF); sd_bit(4'hF); sd_bit(4'h0);
    for (int i = 0; i < 512; i++) begin
      by = 8'(i);
      sd_bit(by[7:4]);
      sd_bit(by[3:0]);
    end
    for (int k = 15; k >= 0; k--) begin
      v = {c[3][k], c[2][k], c[1][k], c[0][k]};
      if (flip && k == 15) v[2] = ~v[2];
      sd_bit(v);
    end
    sd_bit(4'hF);
  endtask

  task automatic snap();
    b_oe = 0; b_bd = 0; b_dn = 0;
  endtask

  initial begin
    rstn = 1'b0; sdclk = 1'b1; dat_a = 1'b1; dat_b = 4'hF;
    start_a = 1'b0; start_b = 1'b0; abort_a = 1'b0; abort_b = 1'b0;
    nblk_a = '0; nblk_b = '0;
    idle_clks(3);
    check("rst_a_flags", 64'({busy_a, blk_done_a, blk_crc_ok_a, done_a, err_crc_a, err_timeout_a, outen_a}), 64'(0));
    check("rst_a_data", 64'({outaddr_a, outblk_a, outbyte_a}), 64'(0));
    check("rst_b_flags", 64'({busy_b, blk_done_b, blk_crc_ok_b, done_b, err_crc_b, err_timeout_b, outen_b}), 64'(0));
    rstn = 1'b1;
    idle_clks(2);

    // single 1-lane block of 0xFF
    b_oe = oe_a; b_bd = bd_a; b_dn = dn_a;
    pulse_start(1'b0, 16'd1);
    check("t1_busy_rise", 64'(busy_a), 64'(1));
    send_block_a();
    idle_clks(3);
    check("t1_outen", 64'(oe_a - b_oe), 64'(512));
    check("t1_blkdone", 64'(bd_a - b_bd), 64'(1));
    check("t1_crc_ok", 64'(ok_a_last), 64'(1));
    check("t1_done", 64'(dn_a - b_dn), 64'(1));
    check("t1_done_with_blk", 64'(dnbd_a), 64'(1));
    check("t1_errs", 64'({err_crc_a, err_timeout_a, busy_a}), 64'(0));

    // 4-lane, three clean blocks
    b_oe = oe_b; b_bd = bd_b; b_dn = dn_b;
    pulse_start(1'b1, 16'd3);
    send_block_b(1'b0); send_block_b(1'b0); send_block_b(1'b0);
    idle_clks(3);
    check("t2_outen", 64'(oe_b - b_oe), 64'(1536));
    check("t2_blkdone", 64'(bd_b - b_bd), 64'(3));
    check("t2_crc_hist", 64'(okh_b[2:0]), 64'(3'b111));
    check("t2_done", 64'(dn_b - b_dn), 64'(1));
    check("t2_errs", 64'({err_crc_b, err_timeout_b, busy_b}), 64'(0));

    // 4-lane, DAT2 CRC corrupted on block 1
    b_bd = bd_b; b_dn = dn_b;
    pulse_start(1'b1, 16'd3);
    send_block_b(1'b0); send_block_b(1'b1);
    idle_clks(3);
    check("t3_err_mid", 64'(err_crc_b), 64'(1));
    check("t3_hist_mid", 64'(okh_b[1:0]), 64'(2'b10));
    check("t3_busy_mid", 64'({busy_b, 8'(dn_b - b_dn)}), 64'({1'b1, 8'd0}));
    send_block_b(1'b0);
    idle_clks(3);
    check("t3_crc_hist", 64'(okh_b[2:0]), 64'(3'b101));
    check("t3_done", 64'(dn_b - b_dn), 64'(1));
    check("t3_blkdone", 64'(bd_b - b_bd), 64'(3));
    check("t3_end", 64'({err_crc_b, busy_b}), 64'(2'b10));

    // start-bit timeout after 101 idle edges
    b_oe = oe_a; b_dn = dn_a;
    pulse_start(1'b0, 16'd1);
    for (int i = 0; i < 100; i++) sd_bit(4'hF);
    idle_clks(3);
    check("t4_no_early_done", 64'({busy_a, 8'(dn_a - b_dn), err_timeout_a}), 64'({1'b1, 8'd0, 1'b0}));
    sd_bit(4'hF);
    idle_clks(3);
    check("t4_done", 64'(dn_a - b_dn), 64'(1));
    check("t4_err_to", 64'({err_timeout_a, busy_a}), 64'(2'b10));
    check("t4_no_outen", 64'(oe_a - b_oe), 64'(0));

    // abort after 100 bytes, then a clean restart
    b_oe = oe_a; b_bd = bd_a; b_dn = dn_a;
    pulse_start(1'b0, 16'd2);
    check("t5_err_cleared", 64'(err_timeout_a), 64'(0));
    sd_bit(4'hF); sd_bit(4'h0);
    for (int i = 0; i < 800; i++) sd_bit(4'hF);
    abort_a = 1'b1;
    @(posedge clk); #1;
    abort_a = 1'b0;
    for (int i = 0; i < 100; i++) sd_bit(4'hF);
    idle_clks(3);
    check("t5_outen", 64'(oe_a - b_oe), 64'(100));
    check("t5_nodone", 64'({8'(dn_a - b_dn), 8'(bd_a - b_bd), busy_a}), 64'(0));
    b_oe = oe_a; b_dn = dn_a;
    pulse_start(1'b0, 16'd1);
    send_block_a();
    idle_clks(3);
    check("t5_rerun", 64'({16'(oe_a - b_oe), 8'(dn_a - b_dn), ok_a_last, err_crc_a, err_timeout_a}),
          64'({16'd512, 8'd1, 1'b1, 1'b0, 1'b0}));

    // asynchronous reset mid-DATA, then nblocks=0 read behaves as one block
    pulse_start(1'b0, 16'd1);
    sd_bit(4'hF); sd_bit(4'h0);
    for (int i = 0; i < 200; i++) sd_bit(4'hF);
    #2 rstn = 1'b0;
    #1;
    check("t6_rst_flags", 64'({busy_a, blk_done_a, blk_crc_ok_a, done_a, err_crc_a, err_timeout_a, outen_a}), 64'(0));
    check("t6_rst_data", 64'({outaddr_a, outblk_a, outbyte_a}), 64'(0));
    @(posedge clk); #1;
    rstn = 1'b1;
    idle_clks(2);
    b_oe = oe_a; b_bd = bd_a; b_dn = dn_a;
    pulse_start(1'b0, 16'd0);
    send_block_a();
    idle_clks(3);
    check("t6_outen", 64'(oe_a - b_oe), 64'(512));
    check("t6_done", 64'({8'(bd_a - b_bd), 8'(dn_a - b_dn), ok_a_last}), 64'({8'd1, 8'd1, 1'b1}));
    check("t6_errs", 64'({err_crc_a, err_timeout_a, busy_a}), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
